clock_period_monitor: RTL and testbench

Measures the period of a slow clock-like signal (e.g. `clk_f10_p0` from clock management) in cycles of the master clock and reports lock or fault status. It is the checking end of the clock generation path. It confirms in hardware that a derived clock is toggling at its expected rate, and feeds status/diagnostic logic. The monitored signal is treated as asynchronous data; the block runs on a single clock.

---
 rtl/clock_period_monitor.sv | 139 +++++++++++++
 tb/tb_clock_period_monitor.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/clock_period_monitor.sv
// Measures the period of an asynchronous clock-like input in clk cycles and reports lock/fault status.
// Latency: outputs update on the clk edge that processes a synchronized rising edge. No backpressure.
// Status outputs are level signals and period_valid is a single-cycle pulse.
module clock_period_monitor #(
    parameter int CLK_FREQUENCY   = 100_000_000,
    parameter int EXPECTED_PERIOD = 10,
    parameter int TOLERANCE       = 1,
    parameter int LOCK_COUNT      = 4,
    parameter int TIMEOUT         = 64,
    parameter int COUNTER_WIDTH   = 16
) (
    input  logic                     clk,
    input  logic                     rstb,
    input  logic                     enable,
    input  logic                     mon_in,
    output logic [COUNTER_WIDTH-1:0] period_value,
    output logic                     period_valid,
    output logic                     locked,
    output logic                     fault
);

    localparam int GW   = $clog2(LOCK_COUNT + 1);
    localparam int LO_I = (EXPECTED_PERIOD > TOLERANCE) ? EXPECTED_PERIOD - TOLERANCE : 0;
    localparam int HI_I = EXPECTED_PERIOD + TOLERANCE;

    localparam logic [COUNTER_WIDTH-1:0] LO_BOUND  = LO_I[COUNTER_WIDTH-1:0];
    localparam logic [COUNTER_WIDTH-1:0] HI_BOUND  = HI_I[COUNTER_WIDTH-1:0];
    localparam logic [COUNTER_WIDTH-1:0] TMO_COUNT = TIMEOUT[COUNTER_WIDTH-1:0];
    localparam logic [GW-1:0]            LOCK_N    = LOCK_COUNT[GW-1:0];

    // A misconfigured instance (timeout not above the good window or not representable) stays idle.
    localparam logic CFG_OK = (CLK_FREQUENCY > 0) && (TIMEOUT > HI_I) &&
                              (longint'(TIMEOUT) < (longint'(1) << COUNTER_WIDTH));

    typedef enum logic [1:0] {IDLE, ACQUIRE, MEASURE, LOCKED} state_t;

    state_t                   state, state_nxt;
    logic [COUNTER_WIDTH-1:0] cnt, cnt_nxt;
    logic [GW-1:0]            good_cnt, good_nxt, good_inc;
    logic [COUNTER_WIDTH-1:0] pv_nxt;
    logic                     pvld_nxt, locked_nxt, fault_nxt;
    logic                     sync1, sync2, sync_d;
    logic                     mon_rise, run_en, in_range;

    // Synchronizer is deliberately outside the enable domain so edges are not lost across enable toggles.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            sync1  <= 1'b0;
            sync2  <= 1'b0;
            sync_d <= 1'b0;
        end else begin
            sync1  <= mon_in;
            sync2  <= sync1;
            sync_d <= sync2;
        end
    end

    assign mon_rise = sync2 & ~sync_d;
    assign run_en   = enable & CFG_OK;
    assign in_range = (cnt >= LO_BOUND) && (cnt <= HI_BOUND);
    assign good_inc = (good_cnt == LOCK_N) ? LOCK_N : good_cnt + GW'(1);

    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        good_nxt   = good_cnt;
        pv_nxt     = period_value;
        pvld_nxt   = 1'b0;
        locked_nxt = locked;
        fault_nxt  = fault;
        if (!run_en) begin
            state_nxt  = IDLE;
            cnt_nxt    = '0;
            good_nxt   = '0;
            pv_nxt     = '0;
            locked_nxt = 1'b0;
            fault_nxt  = 1'b0;
        end else begin
            case (state)
                IDLE: state_nxt = ACQUIRE;
                ACQUIRE: begin
                    if (mon_rise) begin
                        cnt_nxt   = COUNTER_WIDTH'(1);
                        state_nxt = MEASURE;
                    end
                end
                MEASURE, LOCKED: begin
                    // An edge arriving exactly at the timeout count is measured, not timed out.
                    if (mon_rise) begin
                        pv_nxt   = cnt;
                        pvld_nxt = 1'b1;
                        cnt_nxt  = COUNTER_WIDTH'(1);
                        if (in_range) begin
                            good_nxt = good_inc;
                            if (good_inc == LOCK_N) begin
                                locked_nxt = 1'b1;
                                state_nxt  = LOCKED;
                            end
                        end else begin
                            good_nxt   = '0;
                            fault_nxt  = 1'b1;
                            locked_nxt = 1'b0;
                            state_nxt  = MEASURE;
                        end
                    end else if (cnt == TMO_COUNT) begin
                        good_nxt   = '0;
                        fault_nxt  = 1'b1;
                        locked_nxt = 1'b0;
                        state_nxt  = ACQUIRE;
                    end else begin
                        cnt_nxt = cnt + COUNTER_WIDTH'(1);
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state        <= IDLE;
            cnt          <= '0;
            good_cnt     <= '0;
            period_value <= '0;
            period_valid <= 1'b0;
            locked       <= 1'b0;
            fault        <= 1'b0;
        end else begin
            state        <= state_nxt;
            cnt          <= cnt_nxt;
            good_cnt     <= good_nxt;
            period_value <= pv_nxt;
            period_valid <= pvld_nxt;
            locked       <= locked_nxt;
            fault        <= fault_nxt;
        end
    end

endmodule

// File: tb/tb_clock_period_monitor.sv
// Randomized and directed bench for clock_period_monitor against an event-level reference model.
module tb_clock_period_monitor;

    localparam int EXP = 10;
    localparam int TOL = 1;
    localparam int LC  = 4;
    localparam int TMO = 64;

    logic        clk = 1'b0;
    logic        rstb;
    logic        enable;
    logic        mon_in;
    logic [15:0] period_value;
    logic        period_valid;
    logic        locked;
    logic        fault;

    always #5 clk = ~clk;

    clock_period_monitor #(
        .CLK_FREQUENCY  (100_000_000),
        .EXPECTED_PERIOD(EXP),
        .TOLERANCE      (TOL),
        .LOCK_COUNT     (LC),
        .TIMEOUT        (TMO),
        .COUNTER_WIDTH  (16)
    ) dut (
        .clk         (clk),
        .rstb        (rstb),
        .enable      (enable),
        .mon_in      (mon_in),
        .period_value(period_value),
        .period_valid(period_valid),
        .locked      (locked),
        .fault       (fault)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Model: tracks when rising edges are processed and derives results from time differences.
    int          cyc;
    int          m_mode;      // 0 disabled, 1 waiting for first edge, 2 measuring
    int          last_proc;
    int          good_run;
    logic [15:0] m_pv;
    logic        m_pvld, m_locked, m_fault;
    logic        h1, h2, h3;  // mon_in as sampled 1, 2 and 3 clk edges ago
    logic        rst_val;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_mode = 0; last_proc = 0; good_run = 0;
        m_pv = '0; m_pvld = 1'b0; m_locked = 1'b0; m_fault = 1'b0;
        h1 = 1'b0; h2 = 1'b0; h3 = 1'b0;
    endtask

    // Predicts outputs after the next clk edge, given the inputs sampled at it.
    task automatic model_step(input logic mon, input logic en);
        logic rise;
        int   p;
        if (!rstb) begin
            model_reset();
            return;
        end
        cyc++;
        rise = h2 & ~h3;
        h3 = h2; h2 = h1; h1 = mon;
        m_pvld = 1'b0;
        if (!en) begin
            m_mode = 0; good_run = 0; m_pv = '0; m_locked = 1'b0; m_fault = 1'b0;
        end else if (m_mode == 0) begin
            m_mode = 1;
        end else if (m_mode == 1) begin
            if (rise) begin
                last_proc = cyc;
                m_mode = 2;
            end
        end else if (rise) begin
            p = cyc - last_proc;
            last_proc = cyc;
            m_pv = p[15:0];
            m_pvld = 1'b1;
            if (p >= EXP - TOL && p <= EXP + TOL) begin
                good_run = (good_run + 1 > LC) ? LC : good_run + 1;
                if (good_run == LC) m_locked = 1'b1;
            end else begin
                good_run = 0; m_fault = 1'b1; m_locked = 1'b0;
            end
        end else if (cyc - last_proc == TMO) begin
            good_run = 0; m_fault = 1'b1; m_locked = 1'b0; m_mode = 1;
        end
    endtask

    task automatic tick(input logic mon, input logic en);
        @(negedge clk);
        check_val("period_valid", period_valid, m_pvld);
        check_val("period_value", period_value, m_pv);
        check_val("locked", locked, m_locked);
        check_val("fault", fault, m_fault);
        rstb   = rst_val;
        mon_in = mon;
        enable = en;
        model_step(mon, en);
    endtask

    task automatic run_period(input int p, input int n);
        for (int k = 0; k < n; k++)
            for (int i = 0; i < p; i++)
                tick(i < p / 2, 1'b1);
    endtask

    task automatic hold_low(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 1'b1);
    endtask

    task automatic en_low(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 1'b0);
    endtask

    task automatic peek(input string tag, input logic lk, input logic ft);
        @(posedge clk);
        #1;
        check_val({tag, "_locked"}, locked, lk);
        check_val({tag, "_fault"}, fault, ft);
    endtask

    initial begin
        int p, n;
        cyc     = 0;
        rstb    = 1'b0;
        enable  = 1'b0;
        mon_in  = 1'b0;
        rst_val = 1'b0;
        model_reset();
        #2;
        check_val("rst_period_value", period_value, 0);
        check_val("rst_period_valid", period_valid, 0);
        check_val("rst_locked", locked, 0);
        check_val("rst_fault", fault, 0);
        rst_val = 1'b1;
        hold_low(3);

        run_period(10, 8);
        peek("p10", 1'b1, 1'b0);
        check_val("p10_value", period_value, 10);

        en_low(2);
        run_period(12, 5);
        peek("p12", 1'b0, 1'b1);
        check_val("p12_value", period_value, 12);

        en_low(2);
        for (int k = 0; k < 5; k++) begin
            run_period(9, 1);
            run_period(11, 1);
        end
        peek("alt9_11", 1'b1, 1'b0);

        hold_low(100);
        peek("timeout", 1'b0, 1'b1);
        run_period(10, 6);
        peek("relock_fault", 1'b1, 1'b1);

        tick(1'b0, 1'b0);
        @(posedge clk);
        #1;
        check_val("enpulse_value", period_value, 0);
        check_val("enpulse_fault", fault, 0);
        check_val("enpulse_locked", locked, 0);
        run_period(10, 7);

        // Edge landing exactly on the timeout count, then one just past it.
        run_period(TMO, 2);
        run_period(TMO + 1, 2);
        en_low(2);

        for (int k = 0; k < 14; k++) begin
            p = $urandom_range(EXP + 3, EXP - 3);
            n = $urandom_range(6, 2);
            run_period(p, n);
            case ($urandom_range(5, 0))
                0: hold_low($urandom_range(70, 60));
                1: en_low($urandom_range(3, 1));
                default: ;
            endcase
        end

        en_low(2);
        run_period(10, 7);
        tick(1'b1, 1'b1);
        tick(1'b1, 1'b1);
        #1;
        rstb    = 1'b0;
        rst_val = 1'b0;
        model_reset();
        #1;
        check_val("arst_locked", locked, 0);
        check_val("arst_fault", fault, 0);
        check_val("arst_value", period_value, 0);
        check_val("arst_valid", period_valid, 0);
        hold_low(3);
        rst_val = 1'b1;
        run_period(10, 6);
        peek("rst_relock", 1'b1, 1'b0);
        hold_low(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
